// File: rtl/microwave_ctrl_p.sv
// microwave_ctrl_p: keypad-entry BCD mm:ss microwave controller with door interlock and power duty cycling
// Ports: clk_100Hz clock, clear async active-high reset; keypad[9:0], startn, stopn, power_key, door_closed in;
//        sec_ones, sec_tens, mins (BCD), power_level, mag_on, cooking, done out, all registered.
module microwave_ctrl_p #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MIN_DIGITS    = 1,
    parameter int POWER_LEVELS  = 4,
    parameter int DONE_TICKS    = 200
) (
    input  logic                    clk_100Hz,
    input  logic                    clear,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    power_key,
    input  logic                    door_closed,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    cooking,
    output logic                    done
);
    localparam int MW = 4*MIN_DIGITS;
    localparam int PW = $clog2(TICKS_PER_SEC+1);
    localparam int DW = $clog2(DONE_TICKS+1);
    typedef enum logic [2:0] {IDLE, ENTRY, COOK, PAUSE, DONE} state_t;
    state_t        r_state, w_state_n;
    logic [3:0]    r_ones, r_tens, r_pwr, w_ones_n, w_tens_n, w_pwr_n;
    logic [MW-1:0] r_mins, w_mins_n;
    logic [PW-1:0] r_presc, w_presc_n;
    logic [DW-1:0] r_dcnt, w_dcnt_n;
    logic [9:0]    r_kp_q;
    logic          r_startn_q, r_stopn_q, r_pwr_q, r_mag, r_cook, r_done;
    logic [9:0]    w_rise;
    logic          w_key, w_start, w_stop, w_pkey, w_go, w_tick, w_nz, w_dec_zero, w_brw;
    logic [3:0]    w_key_val, w_dec_ones, w_dec_tens, w_pwr_inc;
    logic [MW-1:0] w_dec_mins;
    logic [31:0]   w_thresh;
    // A key press counts only if it is the sole bit rising and nothing else is held.
    assign w_rise     = keypad & ~r_kp_q;
    assign w_key      = $onehot(w_rise) && (keypad == w_rise);
    assign w_start    = r_startn_q & ~startn;
    assign w_stop     = r_stopn_q & ~stopn;
    assign w_pkey     = power_key & ~r_pwr_q;
    assign w_nz       = |{r_ones, r_tens, r_mins};
    assign w_go       = w_start && door_closed && w_nz;
    assign w_tick     = r_presc == PW'(TICKS_PER_SEC-1);
    assign w_pwr_inc  = (r_pwr == 4'(POWER_LEVELS)) ? 4'd1 : r_pwr + 4'd1;
    assign w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_mins == '0);
    assign w_thresh   = (32'(TICKS_PER_SEC) * {28'd0, w_pwr_n}) / 32'(POWER_LEVELS);
    always_comb begin
        w_key_val = 4'd0;
        for (int i = 0; i < 10; i++)
            if (w_rise[i]) w_key_val = 4'(i);
    end
    // One-second BCD decrement: seconds units wrap 0->9, tens 0->5, minute digits 0->9.
    always_comb begin
        w_dec_ones = (r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1;
        w_brw      = r_ones == 4'd0;
        w_dec_tens = w_brw ? ((r_tens == 4'd0) ? 4'd5 : r_tens - 4'd1) : r_tens;
        w_brw      = w_brw && (r_tens == 4'd0);
        w_dec_mins = r_mins;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (w_brw) w_dec_mins[4*i +: 4] = (r_mins[4*i +: 4] == 4'd0) ? 4'd9 : r_mins[4*i +: 4] - 4'd1;
            w_brw = w_brw && (r_mins[4*i +: 4] == 4'd0);
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_ones_n  = r_ones;
        w_tens_n  = r_tens;
        w_mins_n  = r_mins;
        w_pwr_n   = r_pwr;
        w_presc_n = r_presc;
        w_dcnt_n  = r_dcnt;
        case (r_state)
            IDLE, ENTRY, PAUSE: begin
                if (w_stop) begin
                    w_state_n = IDLE;
                    w_ones_n  = 4'd0;
                    w_tens_n  = 4'd0;
                    w_mins_n  = '0;
                end else if (w_go && r_state != IDLE) begin
                    w_state_n = COOK;
                    w_presc_n = '0;
                end else begin
                    if (w_key && r_state != PAUSE) begin
                        w_state_n = ENTRY;
                        w_ones_n  = w_key_val;
                        w_tens_n  = r_ones;
                        w_mins_n  = MW'({r_mins, r_tens});
                    end
                    if (w_pkey) w_pwr_n = w_pwr_inc;
                end
            end
            COOK: begin
                // Reaching zero outranks door-open, which outranks stop; a pause drops the partial second.
                if (w_tick && w_dec_zero) begin
                    w_state_n = DONE;
                    w_ones_n  = w_dec_ones;
                    w_tens_n  = w_dec_tens;
                    w_mins_n  = w_dec_mins;
                    w_presc_n = '0;
                    w_dcnt_n  = '0;
                end else if (!door_closed || w_stop) begin
                    w_state_n = PAUSE;
                end else if (w_tick) begin
                    w_ones_n  = w_dec_ones;
                    w_tens_n  = w_dec_tens;
                    w_mins_n  = w_dec_mins;
                    w_presc_n = '0;
                end else begin
                    w_presc_n = r_presc + PW'(1);
                end
            end
            DONE: begin
                if (w_stop || r_dcnt == DW'(DONE_TICKS-1)) w_state_n = IDLE;
                else w_dcnt_n = r_dcnt + DW'(1);
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_100Hz or posedge clear) begin
        if (clear) begin
            r_state    <= IDLE;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_mins     <= '0;
            r_pwr      <= 4'(POWER_LEVELS);
            r_presc    <= '0;
            r_dcnt     <= '0;
            r_kp_q     <= '0;
            r_startn_q <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_pwr_q    <= 1'b0;
            r_mag      <= 1'b0;
            r_cook     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ones     <= w_ones_n;
            r_tens     <= w_tens_n;
            r_mins     <= w_mins_n;
            r_pwr      <= w_pwr_n;
            r_presc    <= w_presc_n;
            r_dcnt     <= w_dcnt_n;
            r_kp_q     <= keypad;
            r_startn_q <= startn;
            r_stopn_q  <= stopn;
            r_pwr_q    <= power_key;
            r_mag      <= (w_state_n == COOK) && (32'(w_presc_n) < w_thresh);
            r_cook     <= w_state_n == COOK;
            r_done     <= w_state_n == DONE;
        end
    end
    assign sec_ones    = r_ones;
    assign sec_tens    = r_tens;
    assign mins        = r_mins;
    assign power_level = r_pwr;
    assign mag_on      = r_mag;
    assign cooking     = r_cook;
    assign done        = r_done;
endmodule
